// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit path and the message arbiter state type.
package uart_pkg;

  localparam int UART_BITS_N       = 8;
  localparam int UART_CLK_HZ       = 50_000_000;
  localparam int UART_BAUD         = 115_200;
  localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_t;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_msg_arbiter_if.sv
// Requester byte streams on one side, the uart_tx handshake and arbiter status on the other.
interface uart_msg_arbiter_if import uart_pkg::*; #(
  parameter int N_REQ  = 2,
  parameter int BITS_N = UART_BITS_N
);
  localparam int GW = idx_w(N_REQ);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][BITS_N-1:0] req_data;
  logic [N_REQ-1:0]             req_last;
  logic [N_REQ-1:0]             req_ready;
  logic [BITS_N-1:0]            tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic [GW-1:0]                grant_id;
  logic                         busy;
  logic                         timeout_err;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/uart_msg_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after (i_last+1) mod N.
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W-1:0] w_pos;

  // Walk the search order backwards so the nearest candidate is assigned last and wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = N; k >= 1; k--) begin
      w_pos = W'((int'(i_last) + k) % N);
      if (i_req[w_pos]) begin
        o_any = 1'b1;
        o_idx = w_pos;
      end
    end
  end

endmodule

// File: rtl/uart_msg_arbiter.sv
// Grants whole messages from N_REQ byte requesters to a single uart_tx, with an inter-byte timeout.
module uart_msg_arbiter import uart_pkg::*; #(
  parameter int N_REQ          = 2,
  parameter int BITS_N         = UART_BITS_N,
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  uart_msg_arbiter_if.master io_arb
);

  localparam int              GW       = idx_w(N_REQ);
  localparam int              CW       = idx_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]   LAST_RST = GW'(N_REQ - 1);

  arb_state_t        r_state, w_state_nxt;
  logic [GW-1:0]     r_grant, w_grant_nxt;
  logic [GW-1:0]     r_last_grant, w_last_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [GW-1:0]     w_pick_idx;
  logic              w_pick_any;
  logic              w_g_valid, w_g_last, w_accept;
  logic [BITS_N-1:0] w_g_data;
  logic [N_REQ-1:0]  w_req_ready;
  logic [BITS_N-1:0] w_tx_data;
  logic              w_tx_valid;
  logic              w_timeout;

  rr_pick #(.N(N_REQ), .W(GW)) u_rr_pick (
    .i_req  (io_arb.req_valid),
    .i_last (r_last_grant),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_g_valid = io_arb.req_valid[r_grant];
  assign w_g_last  = io_arb.req_last[r_grant];
  assign w_g_data  = io_arb.req_data[r_grant];
  assign w_accept  = w_g_valid & io_arb.tx_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    w_cnt_nxt   = r_cnt;
    w_req_ready = '0;
    w_tx_valid  = 1'b0;
    w_tx_data   = '0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_tx_valid           = w_g_valid;
        w_tx_data            = w_g_data;
        w_req_ready[r_grant] = w_accept;
        if (w_accept) begin
          w_cnt_nxt = '0;
          if (w_g_last) begin
            w_last_nxt  = r_grant;
            w_state_nxt = ST_IDLE;
          end
        end else if (!w_g_valid) begin
          if (r_cnt == CNT_MAX) begin
            w_timeout   = 1'b1;
            w_last_nxt  = r_grant;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Swallow whatever the timed-out owner still offers until it goes quiet.
        w_req_ready[r_grant] = 1'b1;
        if (!w_g_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_RST;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign io_arb.req_ready   = w_req_ready;
  assign io_arb.tx_valid    = w_tx_valid;
  assign io_arb.tx_data     = w_tx_data;
  assign io_arb.grant_id    = r_grant;
  assign io_arb.busy        = (r_state != ST_IDLE);
  assign io_arb.timeout_err = w_timeout;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Scoreboard bench for uart_msg_arbiter: requester queues feed the DUT, a monitor checks each accepted byte.
module tb_uart_msg_arbiter;

  localparam int NR = 2;
  localparam int BW = 8;
  localparam int TO = 16;

  typedef struct { logic [7:0] d; logic l; } stim_t;
  typedef struct { int gid; logic [7:0] d; } exp_t;

  logic  CLOCK_50 = 1'b0;
  logic  rst      = 1'b1;
  int    n_vec = 0, n_err = 0, cyc = 0;
  stim_t rq [NR][$];
  exp_t  exp_q[$];
  bit    hold_low = 1'b0;
  int    uart_busy = 0;
  int    n_timeout = 0, last_acc_cyc = 0, to_delta = -1;

  uart_msg_arbiter_if #(.N_REQ(NR), .BITS_N(BW)) bus_if ();

  uart_msg_arbiter #(.N_REQ(NR), .BITS_N(BW), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .io_arb   (bus_if)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, expv);
    end
  endtask

  task automatic fail_tmo(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, actual none required event", nm);
  endtask

  task automatic stim(input int r, input logic [7:0] d, input logic l);
    stim_t s;
    s.d = d;
    s.l = l;
    rq[r].push_back(s);
  endtask

  task automatic expb(input int g, input logic [7:0] d);
    exp_t e;
    e.gid = g;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string nm, input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      @(negedge CLOCK_50); #2;
      if (exp_q.size() == 0 && rq[0].size() == 0 && rq[1].size() == 0 && !bus_if.busy) break;
    end
    n_vec++;
    if (k == max_cyc) begin
      n_err++;
      $display("FAIL %s: actual %0d bytes outstanding required 0", nm, exp_q.size());
    end
  endtask

  // Requesters: present queue head each cycle, drop it once it is accepted.
  initial begin
    bus_if.req_valid = '0;
    bus_if.req_data  = '0;
    bus_if.req_last  = '0;
    forever begin
      @(negedge CLOCK_50);
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() > 0) begin
          bus_if.req_valid[i] = 1'b1;
          bus_if.req_data[i]  = rq[i][0].d;
          bus_if.req_last[i]  = rq[i][0].l;
        end else begin
          bus_if.req_valid[i] = 1'b0;
          bus_if.req_data[i]  = '0;
          bus_if.req_last[i]  = 1'b0;
        end
      end
      #1;
      for (int i = 0; i < NR; i++)
        if (bus_if.req_valid[i] && bus_if.req_ready[i] && rq[i].size() > 0)
          void'(rq[i].pop_front());
    end
  end

  // uart_tx stand-in: ready only while idle, busy for two cycles after each byte.
  initial begin
    bus_if.tx_ready = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      bus_if.tx_ready = !hold_low && (uart_busy == 0);
      #1;
      if (bus_if.tx_valid && bus_if.tx_ready) uart_busy = 2;
      else if (uart_busy > 0) uart_busy--;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLOCK_50); #1;
      if (bus_if.timeout_err) begin
        n_timeout++;
        to_delta = cyc - last_acc_cyc;
      end
      if (bus_if.tx_valid && bus_if.tx_ready) begin
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: actual %02h from grant %0d required no byte", bus_if.tx_data, bus_if.grant_id);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(bus_if.tx_data), 32'(e.d));
          chk("tx_grant", 32'(bus_if.grant_id), e.gid);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual no finish required finish, %0d vectors", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit found;
    int bad;
    int to_before;

    repeat (3) @(negedge CLOCK_50);
    #2;
    chk("rst_tx_valid", 32'(bus_if.tx_valid), 0);
    chk("rst_tx_data", 32'(bus_if.tx_data), 0);
    chk("rst_req_ready", 32'(bus_if.req_ready), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_timeout", 32'(bus_if.timeout_err), 0);
    rst = 1'b0;
    @(negedge CLOCK_50); #2;
    chk("rst_grant_id", 32'(bus_if.grant_id), 0);

    // req0 alone, three-byte message
    stim(0, 8'h7B, 0); stim(0, 8'h22, 0); stim(0, 8'h0A, 1);
    expb(0, 8'h7B); expb(0, 8'h22); expb(0, 8'h0A);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLOCK_50); #2;
      if (bus_if.tx_valid && bus_if.tx_ready && bus_if.tx_data == 8'h0A) begin found = 1; break; end
    end
    if (!found) fail_tmo("t1_last_byte");
    else begin
      chk("t1_busy_at_last", 32'(bus_if.busy), 1);
      chk("t1_grant", 32'(bus_if.grant_id), 0);
      @(negedge CLOCK_50); #2;
      chk("t1_busy_after", 32'(bus_if.busy), 0);
    end
    wait_done("t1_done", 100);

    // req1 two messages back to back, req0 joins during the first
    stim(1, 8'h11, 0); stim(1, 8'h12, 0); stim(1, 8'h13, 1);
    stim(1, 8'h21, 0); stim(1, 8'h22, 1);
    expb(1, 8'h11); expb(1, 8'h12); expb(1, 8'h13);
    expb(0, 8'h31); expb(0, 8'h32);
    expb(1, 8'h21); expb(1, 8'h22);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLOCK_50); #2;
      if (exp_q.size() == 6) begin found = 1; break; end
    end
    if (!found) fail_tmo("t2_first_byte");
    stim(0, 8'h31, 0); stim(0, 8'h32, 1);
    wait_done("t2_done", 300);

    // req0 stalls after one byte without last; req1 waits behind it
    to_before = n_timeout;
    stim(0, 8'h44, 0);
    stim(1, 8'h55, 0); stim(1, 8'h56, 1);
    expb(0, 8'h44); expb(1, 8'h55); expb(1, 8'h56);
    wait_done("t3_done", 200);
    chk("t3_timeout_pulses", n_timeout - to_before, 1);
    chk("t3_timeout_delay", to_delta, TO);

    // uart held busy for 1000 cycles with a byte pending
    hold_low = 1'b1;
    stim(0, 8'h66, 0); stim(0, 8'h67, 1);
    expb(0, 8'h66); expb(0, 8'h67);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLOCK_50); #2;
      if (bus_if.tx_valid) begin found = 1; break; end
    end
    if (!found) fail_tmo("t4_tx_valid");
    bad = 0;
    repeat (1000) begin
      @(negedge CLOCK_50); #2;
      if (!(bus_if.tx_valid === 1'b1 && bus_if.tx_data === 8'h66 &&
            bus_if.timeout_err === 1'b0 && bus_if.busy === 1'b1)) bad++;
    end
    chk("t4_stall_stable", bad, 0);
    hold_low = 1'b0;
    wait_done("t4_done", 100);

    // reset while the second byte of a req1 message is on offer
    stim(1, 8'h77, 0); stim(1, 8'h78, 0); stim(1, 8'h79, 1);
    expb(1, 8'h77);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLOCK_50); #2;
      if (bus_if.tx_valid && bus_if.tx_data == 8'h78) begin found = 1; break; end
    end
    if (!found) fail_tmo("t5_second_byte");
    #1 rst = 1'b1;
    #1;
    chk("t5_tx_valid", 32'(bus_if.tx_valid), 0);
    chk("t5_tx_data", 32'(bus_if.tx_data), 0);
    chk("t5_req_ready", 32'(bus_if.req_ready), 0);
    chk("t5_grant_id", 32'(bus_if.grant_id), 0);
    chk("t5_busy", 32'(bus_if.busy), 0);
    chk("t5_timeout", 32'(bus_if.timeout_err), 0);
    chk("t5_first_byte_sent", exp_q.size(), 0);
    rq[0].delete();
    rq[1].delete();
    repeat (2) @(negedge CLOCK_50);
    #3 rst = 1'b0;

    // both requesters at once straight after reset: req0 first, no interleave
    stim(0, 8'hA0, 0); stim(0, 8'hA1, 1);
    stim(1, 8'hB0, 0); stim(1, 8'hB1, 1);
    expb(0, 8'hA0); expb(0, 8'hA1); expb(1, 8'hB0); expb(1, 8'hB1);
    wait_done("t6_done", 100);

    chk("total_timeouts", n_timeout, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
